register_writeback_queue: RTL and testbench

REGISTER_WRITEBACK_QUEUE -- requirements
Module: register_writeback_queue

---
 rtl/register_writeback_queue_pkg.sv | 17 +
 rtl/register_writeback_queue_wb_forward_select.sv | 29 ++
 rtl/register_writeback_queue.sv | 158 +++++++++++++++
 tb/tb_register_writeback_queue.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/register_writeback_queue_pkg.sv
// Shared register-file constants for the writeback queue and its forwarding select.
package register_writeback_queue_pkg;

    localparam int unsigned REG_ADDR_W     = 5;
    localparam int unsigned REG_COUNT      = 32;
    localparam int unsigned DATA_W_DEFAULT = 64;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // Zero register: writes are dropped, reads are never forwarded.
    localparam reg_addr_t XZR_ADDR = reg_addr_t'(REG_COUNT - 1);

    function automatic logic is_xzr(input reg_addr_t addr);
        return addr == XZR_ADDR;
    endfunction

endpackage

// File: rtl/register_writeback_queue_wb_forward_select.sv
// Per-read-port priority select: returns the youngest valid candidate whose
// address matches rd_addr, else the raw register-file data.
module wb_forward_select
    import register_writeback_queue_pkg::*;
#(
    parameter int unsigned N = 5,
    parameter int unsigned W = DATA_W_DEFAULT
) (
    input  logic [REG_ADDR_W-1:0]   rd_addr,
    input  logic [W-1:0]            raw_data,
    input  logic [N-1:0]            cand_valid,
    input  logic [N*REG_ADDR_W-1:0] cand_addr,
    input  logic [N*W-1:0]          cand_data,
    output logic [W-1:0]            fwd_data
);

    // Candidates are ordered oldest (index 0) to youngest, so later hits win.
    always_comb begin
        fwd_data = raw_data;
        if (!is_xzr(rd_addr)) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (cand_valid[i] && (cand_addr[i*REG_ADDR_W +: REG_ADDR_W] == rd_addr)) begin
                    fwd_data = cand_data[i*W +: W];
                end
            end
        end
    end

endmodule

// File: rtl/register_writeback_queue.sv
// Writeback queue in front of the register file: FIFO of pending writes drained
// one per cycle, with optional read forwarding enabled by macro WB_FORWARD_EN.
module register_writeback_queue
    import register_writeback_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned n     = DATA_W_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_ADDR_W-1:0] in_da,
    input  logic [n-1:0]          in_d,
    output logic [REG_ADDR_W-1:0] DA,
    output logic [n-1:0]          D,
    output logic                  w,
    input  logic [REG_ADDR_W-1:0] AA,
    input  logic [REG_ADDR_W-1:0] AB,
    input  logic [n-1:0]          A_in,
    input  logic [n-1:0]          B_in,
    output logic [n-1:0]          A_fwd,
    output logic [n-1:0]          B_fwd,
    output logic                  pending
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [REG_ADDR_W-1:0] mem_da_q [DEPTH];
    logic [REG_ADDR_W-1:0] mem_da_d [DEPTH];
    logic [n-1:0]          mem_d_q  [DEPTH];
    logic [n-1:0]          mem_d_d  [DEPTH];

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [REG_ADDR_W-1:0] da_q, da_d;
    logic [n-1:0]          d_q, d_d;
    logic                  w_q, w_d;

    logic push;
    logic pop;

    assign in_ready = (count_q < DEPTH_CNT);
    assign pop      = (count_q != '0);
    assign push     = in_valid && in_ready && !is_xzr(in_da);

    always_comb begin
        mem_da_d = mem_da_q;
        mem_d_d  = mem_d_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        da_d     = da_q;
        d_d      = d_q;
        w_d      = 1'b0;

        if (push) begin
            mem_da_d[wr_ptr_q] = in_da;
            mem_d_d[wr_ptr_q]  = in_d;
            wr_ptr_d           = wr_ptr_q + 1'b1;
        end

        // Pop reads the pre-edge head, so a push into an empty queue waits a cycle.
        if (pop) begin
            da_d     = mem_da_q[rd_ptr_q];
            d_d      = mem_d_q[rd_ptr_q];
            w_d      = 1'b1;
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_da_q <= '{default: '0};
            mem_d_q  <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            da_q     <= '0;
            d_q      <= '0;
            w_q      <= 1'b0;
        end else begin
            mem_da_q <= mem_da_d;
            mem_d_q  <= mem_d_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            da_q     <= da_d;
            d_q      <= d_d;
            w_q      <= w_d;
        end
    end

    assign DA      = da_q;
    assign D       = d_q;
    assign w       = w_q;
    assign pending = (count_q != '0) || w_q;

`ifdef WB_FORWARD_EN
    localparam int unsigned NCAND = DEPTH + 1;

    logic [NCAND-1:0]            cand_valid;
    logic [NCAND*REG_ADDR_W-1:0] cand_addr;
    logic [NCAND*n-1:0]          cand_data;
    logic [PTR_W-1:0]            slot;

    // Slot 0 is the write being presented now; queue entries follow head to tail.
    always_comb begin
        cand_valid = '0;
        cand_addr  = '0;
        cand_data  = '0;
        slot       = '0;
        cand_valid[0]               = w_q;
        cand_addr[REG_ADDR_W-1:0]   = da_q;
        cand_data[n-1:0]            = d_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            slot = rd_ptr_q + PTR_W'(i);
            cand_valid[i+1]                             = (CNT_W'(i) < count_q);
            cand_addr[(i+1)*REG_ADDR_W +: REG_ADDR_W]   = mem_da_q[slot];
            cand_data[(i+1)*n +: n]                     = mem_d_q[slot];
        end
    end

    wb_forward_select #(.N(NCAND), .W(n)) u_fwd_a (
        .rd_addr    (AA),
        .raw_data   (A_in),
        .cand_valid (cand_valid),
        .cand_addr  (cand_addr),
        .cand_data  (cand_data),
        .fwd_data   (A_fwd)
    );

    wb_forward_select #(.N(NCAND), .W(n)) u_fwd_b (
        .rd_addr    (AB),
        .raw_data   (B_in),
        .cand_valid (cand_valid),
        .cand_addr  (cand_addr),
        .cand_data  (cand_data),
        .fwd_data   (B_fwd)
    );
`else
    logic unused_fwd_addr;

    assign unused_fwd_addr = ^{AA, AB};
    assign A_fwd = A_in;
    assign B_fwd = B_in;
`endif

endmodule

// File: tb/tb_register_writeback_queue.sv
// Directed self-checking bench for register_writeback_queue (DEPTH=4, n=64).
module tb_register_writeback_queue;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_da;
    logic [63:0] in_d;
    logic [4:0]  DA;
    logic [63:0] D;
    logic        w;
    logic [4:0]  AA;
    logic [4:0]  AB;
    logic [63:0] A_in;
    logic [63:0] B_in;
    logic [63:0] A_fwd;
    logic [63:0] B_fwd;
    logic        pending;

    int vectors;
    int miscompares;

    register_writeback_queue #(.DEPTH(4), .n(64)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_da    (in_da),
        .in_d     (in_d),
        .DA       (DA),
        .D        (D),
        .w        (w),
        .AA       (AA),
        .AB       (AB),
        .A_in     (A_in),
        .B_in     (B_in),
        .A_fwd    (A_fwd),
        .B_fwd    (B_fwd),
        .pending  (pending)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1;
        vectors++; if (w !== 1'b0) begin miscompares++; $display("FAIL reset_w: got %0b expected 0", w); end
        vectors++; if (DA !== 5'd0) begin miscompares++; $display("FAIL reset_DA: got %0d expected 0", DA); end
        vectors++; if (D !== 64'd0) begin miscompares++; $display("FAIL reset_D: got %0h expected 0", D); end
        vectors++; if (pending !== 1'b0) begin miscompares++; $display("FAIL reset_pending: got %0b expected 0", pending); end
        step();
        step();
        reset = 1'b1;
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
        step();
        vectors++; if (w !== 1'b0) begin miscompares++; $display("FAIL reset_idle_w: got %0b expected 0", w); end
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_da = 5'd5; in_d = 64'hDEAD;
        step();
        in_valid = 1'b0;
        vectors++; if (w !== 1'b0) begin miscompares++; $display("FAIL single_w_early: got %0b expected 0", w); end
        vectors++; if (pending !== 1'b1) begin miscompares++; $display("FAIL single_pending_q: got %0b expected 1", pending); end
        step();
        vectors++; if (w !== 1'b1) begin miscompares++; $display("FAIL single_w: got %0b expected 1", w); end
        vectors++; if (DA !== 5'd5) begin miscompares++; $display("FAIL single_DA: got %0d expected 5", DA); end
        vectors++; if (D !== 64'hDEAD) begin miscompares++; $display("FAIL single_D: got %0h expected dead", D); end
        step();
        vectors++; if (w !== 1'b0) begin miscompares++; $display("FAIL single_w_after: got %0b expected 0", w); end
        vectors++; if (pending !== 1'b0) begin miscompares++; $display("FAIL single_pending_after: got %0b expected 0", pending); end
        vectors++; if (DA !== 5'd5) begin miscompares++; $display("FAIL single_DA_hold: got %0d expected 5", DA); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_da = 5'(i + 1); in_d = 64'h100 + 64'(i);
            vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_in_ready[%0d]: got %0b expected 1", i, in_ready); end
            step();
            if (i == 0) begin
                vectors++; if (w !== 1'b0) begin miscompares++; $display("FAIL b2b_w[0]: got %0b expected 0", w); end
            end else begin
                vectors++; if (w !== 1'b1) begin miscompares++; $display("FAIL b2b_w[%0d]: got %0b expected 1", i, w); end
                vectors++; if (DA !== 5'(i)) begin miscompares++; $display("FAIL b2b_DA[%0d]: got %0d expected %0d", i, DA, i); end
                vectors++; if (D !== 64'h100 + 64'(i - 1)) begin miscompares++; $display("FAIL b2b_D[%0d]: got %0h expected %0h", i, D, 64'h100 + 64'(i - 1)); end
            end
        end
        in_valid = 1'b0;
        step();
        vectors++; if (w !== 1'b1) begin miscompares++; $display("FAIL b2b_w_last: got %0b expected 1", w); end
        vectors++; if (DA !== 5'd5) begin miscompares++; $display("FAIL b2b_DA_last: got %0d expected 5", DA); end
        vectors++; if (D !== 64'h104) begin miscompares++; $display("FAIL b2b_D_last: got %0h expected 104", D); end
        step();
        vectors++; if (w !== 1'b0) begin miscompares++; $display("FAIL b2b_w_end: got %0b expected 0", w); end
        vectors++; if (pending !== 1'b0) begin miscompares++; $display("FAIL b2b_pending_end: got %0b expected 0", pending); end
    endtask

    task automatic test_xzr();
        in_valid = 1'b1; in_da = 5'd31; in_d = 64'h1234;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL xzr_in_ready: got %0b expected 1", in_ready); end
        step();
        in_valid = 1'b0;
        vectors++; if (pending !== 1'b0) begin miscompares++; $display("FAIL xzr_pending: got %0b expected 0", pending); end
        vectors++; if (w !== 1'b0) begin miscompares++; $display("FAIL xzr_w0: got %0b expected 0", w); end
        step();
        vectors++; if (w !== 1'b0) begin miscompares++; $display("FAIL xzr_w1: got %0b expected 0", w); end
        vectors++; if (pending !== 1'b0) begin miscompares++; $display("FAIL xzr_pending1: got %0b expected 0", pending); end
    endtask

    task automatic test_forward();
        logic        fwd_on;
        logic [63:0] exp_a;
`ifdef WB_FORWARD_EN
        fwd_on = 1'b1;
`else
        fwd_on = 1'b0;
`endif
        AA = 5'd7; A_in = 64'd0; AB = 5'd31; B_in = 64'hBBBB;
        in_valid = 1'b1; in_da = 5'd7; in_d = 64'd1;
        step();
        in_da = 5'd7; in_d = 64'd2;
        exp_a = fwd_on ? 64'd1 : A_in;
        vectors++; if (A_fwd !== exp_a) begin miscompares++; $display("FAIL fwd_first: got %0h expected %0h", A_fwd, exp_a); end
        step();
        in_valid = 1'b0;
        exp_a = fwd_on ? 64'd2 : A_in;
        vectors++; if (A_fwd !== exp_a) begin miscompares++; $display("FAIL fwd_second_q: got %0h expected %0h", A_fwd, exp_a); end
        vectors++; if (B_fwd !== 64'hBBBB) begin miscompares++; $display("FAIL fwd_xzr_b: got %0h expected bbbb", B_fwd); end
        AB = 5'd7;
        #1;
        exp_a = fwd_on ? 64'd2 : B_in;
        vectors++; if (B_fwd !== exp_a) begin miscompares++; $display("FAIL fwd_b_port: got %0h expected %0h", B_fwd, exp_a); end
        AB = 5'd31;
        step();
        exp_a = fwd_on ? 64'd2 : A_in;
        vectors++; if (pending !== 1'b1) begin miscompares++; $display("FAIL fwd_pending: got %0b expected 1", pending); end
        vectors++; if (A_fwd !== exp_a) begin miscompares++; $display("FAIL fwd_second_w: got %0h expected %0h", A_fwd, exp_a); end
        step();
        A_in = 64'h55;
        #1;
        vectors++; if (pending !== 1'b0) begin miscompares++; $display("FAIL fwd_pending_end: got %0b expected 0", pending); end
        vectors++; if (A_fwd !== 64'h55) begin miscompares++; $display("FAIL fwd_passthru: got %0h expected 55", A_fwd); end
    endtask

    task automatic test_reset_mid_drain();
        int pulses;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_da = 5'(10 + i); in_d = 64'hA0 + 64'(i);
            step();
        end
        in_valid = 1'b0;
        vectors++; if (w !== 1'b1 || DA !== 5'd11) begin miscompares++; $display("FAIL rst_mid_pre: got w=%0b DA=%0d expected w=1 DA=11", w, DA); end
        reset = 1'b0;
        #1;
        vectors++; if (w !== 1'b0) begin miscompares++; $display("FAIL rst_mid_w: got %0b expected 0", w); end
        vectors++; if (pending !== 1'b0) begin miscompares++; $display("FAIL rst_mid_pending: got %0b expected 0", pending); end
        step();
        reset = 1'b1;
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_mid_in_ready: got %0b expected 1", in_ready); end
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (w === 1'b1) pulses++;
        end
        vectors++; if (pulses !== 0) begin miscompares++; $display("FAIL rst_mid_pulses: got %0d expected 0", pulses); end
    endtask

    task automatic test_random();
        logic [63:0] exp_regs [32];
        logic [63:0] obs_regs [32];
        logic [4:0]  q_da [$];
        logic [63:0] q_d  [$];
        int seq_err;
        int ready_low;
        int reg_err;
        int accepted;
        int pulses;
        for (int r = 0; r < 32; r++) begin
            exp_regs[r] = '0;
            obs_regs[r] = '0;
        end
        seq_err = 0; ready_low = 0; reg_err = 0; accepted = 0; pulses = 0;
        for (int c = 0; c < 210; c++) begin
            if (w === 1'b1) begin
                pulses++;
                obs_regs[DA] = D;
                if (q_da.size() == 0) seq_err++;
                else begin
                    if (DA !== q_da[0] || D !== q_d[0]) seq_err++;
                    void'(q_da.pop_front());
                    void'(q_d.pop_front());
                end
            end
            if (c < 200) begin
                in_valid = 1'($urandom_range(0, 1));
                in_da    = 5'($urandom_range(0, 31));
                in_d     = {32'($urandom), 32'($urandom)};
            end else begin
                in_valid = 1'b0;
            end
            if (in_ready !== 1'b1) ready_low++;
            if (in_valid && in_da != 5'd31) begin
                accepted++;
                exp_regs[in_da] = in_d;
                q_da.push_back(in_da);
                q_d.push_back(in_d);
            end
            step();
        end
        for (int r = 0; r < 32; r++) if (obs_regs[r] !== exp_regs[r]) reg_err++;
        vectors++; if (seq_err !== 0) begin miscompares++; $display("FAIL rand_order: got %0d bad writes expected 0", seq_err); end
        vectors++; if (pulses !== accepted) begin miscompares++; $display("FAIL rand_pulses: got %0d expected %0d", pulses, accepted); end
        vectors++; if (reg_err !== 0) begin miscompares++; $display("FAIL rand_regs: got %0d wrong registers expected 0", reg_err); end
        vectors++; if (ready_low !== 0) begin miscompares++; $display("FAIL rand_in_ready: got %0d low cycles expected 0", ready_low); end
        vectors++; if (pending !== 1'b0) begin miscompares++; $display("FAIL rand_pending_end: got %0b expected 0", pending); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        in_valid = 1'b0; in_da = '0; in_d = '0;
        AA = 5'd0; AB = 5'd0; A_in = '0; B_in = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_xzr();
        test_forward();
        test_reset_mid_drain();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
